// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg -- shared constants for the register dump block.
//   FSM state encodings, ASCII constants, per-line character count,
//   total line count and the nibble-to-ASCII helper.
//   Build option REG_DUMP_PC_EN adds a 33rd line carrying the program counter.
package reg_dump_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ADDR    = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_SEND    = 3'd3;
    localparam logic [2:0] ST_NEXT    = 3'd4;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    // 8 hex digits followed by a line feed
    localparam logic [3:0] CHARS_PER_LINE = 4'd9;

`ifdef REG_DUMP_PC_EN
    localparam logic [5:0] LINE_COUNT = 6'd33;
`else
    localparam logic [5:0] LINE_COUNT = 6'd32;
`endif
    localparam logic [5:0] LAST_LINE = LINE_COUNT - 6'd1;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return ASCII_ZERO + {4'd0, nib};
        else
            return ASCII_A + {4'd0, nib - 4'd10};
    endfunction

endpackage

// File: rtl/reg_dump_uart_tx.sv
// reg_dump_uart_tx -- 8N1 byte serialiser.
//   clk_cpu  in   clock
//   reset    in   synchronous active-high reset
//   data     in   byte to send
//   valid    in   data is offered
//   ready    out  byte accepted on an edge where valid && ready
//   tx       out  serial line, idle high
// ready is raised combinationally in the last cycle of the stop bit, so a
// byte offered then starts its start bit on the very next edge (no gap).
module reg_dump_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_cpu,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    logic        active;
    logic [15:0] baud_cnt;
    logic [3:0]  bit_cnt;
    logic [8:0]  shift;
    logic        frame_end;

    // bit_cnt counts bits still to shift out after the current one
    assign frame_end = (baud_cnt == 16'd0) && (bit_cnt == 4'd0);
    assign ready     = !active || frame_end;

    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            active   <= 1'b0;
            baud_cnt <= 16'd0;
            bit_cnt  <= 4'd0;
            shift    <= 9'd0;
            tx       <= 1'b1;
        end else if (valid && ready) begin
            active   <= 1'b1;
            tx       <= 1'b0;
            shift    <= {1'b1, data};
            bit_cnt  <= 4'd9;
            baud_cnt <= BIT_LAST;
        end else if (active) begin
            if (baud_cnt != 16'd0) begin
                baud_cnt <= baud_cnt - 16'd1;
            end else if (bit_cnt != 4'd0) begin
                tx       <= shift[0];
                shift    <= {1'b0, shift[8:1]};
                bit_cnt  <= bit_cnt - 4'd1;
                baud_cnt <= BIT_LAST;
            end else begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_dump.sv
// reg_dump -- dumps all 32 registers as ASCII hex lines over a UART.
//   clk_cpu       in   clock
//   reset         in   synchronous active-high reset
//   start         in   dump request (ignored while busy)
//   reg_dbg_adrs  out  register-file debug read address
//   reg_dbg_q     in   register-file debug read data (one cycle latency)
//   pc            in   program counter, dumped as a final line only when
//                      REG_DUMP_PC_EN is defined
//   tx            out  UART serial out, 8N1
//   busy          out  dump in progress
//   done          out  one-cycle pulse when the dump completes
//
// state    | meaning
// IDLE     | waiting for start
// ADDR     | reg_dbg_adrs presented, read data settling
// CAPTURE  | latch word, reset char count
// SEND     | stream 8 hex digits + LF, then wait for the last stop bit
// NEXT     | advance index or finish with done
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk_cpu,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  reg_dbg_adrs,
    input  logic [31:0] reg_dbg_q,
    input  logic [31:0] pc,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    logic [2:0]  state;
    logic [5:0]  index;
    logic [31:0] word;
    logic [3:0]  char_cnt;
    logic [31:0] capture_word;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

`ifdef REG_DUMP_PC_EN
    // index 32 is the extra program-counter line
    assign capture_word = index[5] ? pc : reg_dbg_q;
`else
    logic unused_pc;
    assign unused_pc    = ^pc;
    assign capture_word = reg_dbg_q;
`endif

    assign reg_dbg_adrs = index[4:0];
    assign busy         = (state != ST_IDLE);

    // word is shifted left a nibble per accepted digit, so the current
    // digit is always the top nibble
    assign tx_data  = (char_cnt == 4'd8) ? ASCII_LF : hex_ascii(word[31:28]);
    assign tx_valid = (state == ST_SEND) && (char_cnt != CHARS_PER_LINE);

    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            state    <= ST_IDLE;
            index    <= 6'd0;
            word     <= 32'd0;
            char_cnt <= 4'd0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        index <= 6'd0;
                        state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    word     <= capture_word;
                    char_cnt <= 4'd0;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (char_cnt == CHARS_PER_LINE) begin
                        // ready here marks the end of the LF stop bit
                        if (tx_ready)
                            state <= ST_NEXT;
                    end else if (tx_ready) begin
                        char_cnt <= char_cnt + 4'd1;
                        word     <= {word[27:0], 4'h0};
                    end
                end
                ST_NEXT: begin
                    if (index == LAST_LINE) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end else begin
                        index <= index + 6'd1;
                        state <= ST_ADDR;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    reg_dump_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk_cpu (clk_cpu),
        .reset   (reset),
        .data    (tx_data),
        .valid   (tx_valid),
        .ready   (tx_ready),
        .tx      (tx)
    );

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump -- scoreboard bench for reg_dump with CLKS_PER_BIT=4.
module tb_reg_dump;

    localparam int CPB = 4;
`ifdef REG_DUMP_PC_EN
    localparam int N_LINES = 33;
`else
    localparam int N_LINES = 32;
`endif
    localparam int N_BYTES = N_LINES * 9;
    localparam logic [31:0] PC_VAL = 32'h00400010;

    logic        clk_cpu = 1'b0;
    logic        reset   = 1'b1;
    logic        start   = 1'b0;
    logic [4:0]  reg_dbg_adrs;
    logic [31:0] reg_dbg_q;
    logic [31:0] pc = PC_VAL;
    logic        tx;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    always #5 clk_cpu = ~clk_cpu;

    reg_dump #(.CLKS_PER_BIT(CPB)) dut (
        .clk_cpu      (clk_cpu),
        .reset        (reset),
        .start        (start),
        .reg_dbg_adrs (reg_dbg_adrs),
        .reg_dbg_q    (reg_dbg_q),
        .pc           (pc),
        .tx           (tx),
        .busy         (busy),
        .done         (done)
    );

    function automatic logic [31:0] model_reg(input int a);
        case (a)
            0:       return 32'h00000000;
            1:       return 32'hDEADBEEF;
            5:       return 32'hA0B1C2D3;
            default: return 32'h12345678;
        endcase
    endfunction

    // register file with one cycle read latency
    always @(posedge clk_cpu) reg_dbg_q <= model_reg(int'(reg_dbg_adrs));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0] exp_q[$];

    function automatic logic [7:0] hex_chr(input logic [3:0] n);
        if (n < 4'd10) return 8'd48 + 8'(n);
        else           return 8'd55 + 8'(n);
    endfunction

    task automatic push_dump();
        logic [31:0] w;
        for (int l = 0; l < N_LINES; l++) begin
            w = (l == 32) ? PC_VAL : model_reg(l);
            for (int d = 7; d >= 0; d--) exp_q.push_back(hex_chr(w[d*4 +: 4]));
            exp_q.push_back(8'h0A);
        end
    endtask

    // ---------------- monitor ----------------
    int         cyc = 0;
    always @(posedge clk_cpu) cyc <= cyc + 1;

    logic       mon_active   = 1'b0;
    int         mon_cnt      = 0;
    logic [9:0] mon_bits     = '0;
    int         wid_err      = 0;
    int         rx_bytes     = 0;
    int         frame_cycles = 0;
    int         done_cnt     = 0;
    int         first_low    = -1;
    int         adr5_cnt     = 0;
    logic       expect_start = 1'b0;
    logic       prev_done    = 1'b0;
    logic [7:0] e_byte;

    always @(negedge clk_cpu) begin
        if (reset) begin
            mon_active   = 1'b0;
            mon_cnt      = 0;
            wid_err      = 0;
            expect_start = 1'b0;
            prev_done    = 1'b0;
        end else begin
            if (expect_start) begin
                chk("b2b_gap", tx, 0);
                expect_start = 1'b0;
            end
            if (!mon_active && tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                if (first_low < 0) first_low = cyc;
            end
            if (mon_active) begin
                if (mon_cnt % 4 == 0) mon_bits[mon_cnt/4] = tx;
                else if (tx !== mon_bits[mon_cnt/4]) wid_err++;
                mon_cnt++;
                if (mon_cnt == 40) begin
                    mon_active = 1'b0;
                    frame_cycles += 40;
                    rx_bytes++;
                    chk("stop_bit", mon_bits[9], 1);
                    chk("bit_width", wid_err, 0);
                    wid_err = 0;
                    if (exp_q.size() == 0) begin
                        chk("sb_depth", exp_q.size(), 1);
                    end else begin
                        e_byte = exp_q.pop_front();
                        chk("byte", mon_bits[8:1], e_byte);
                        if (e_byte != 8'h0A) expect_start = 1'b1;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_busy", busy, 0);
            end
            if (prev_done) chk("done_width", done, 0);
            prev_done = done;
            if (busy && reg_dbg_adrs == 5'd5) adr5_cnt++;
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk_cpu);
        #1;
    endtask

    task automatic pulse_start(output int edge_n);
        start = 1'b1;
        tick();
        edge_n = cyc;
        start = 1'b0;
    endtask

    task automatic reset_counters();
        rx_bytes     = 0;
        frame_cycles = 0;
        done_cnt     = 0;
        first_low    = -1;
        adr5_cnt     = 0;
        exp_q.delete();
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 20000) begin
            tick();
            n++;
        end
        chk(tag, (done_cnt != 0), 1);
    endtask

    int sedge;
    int n;

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_adrs", reg_dbg_adrs, 0);
        reset = 1'b0;
        tick();

        // full dump, latency and width
        reset_counters();
        push_dump();
        pulse_start(sedge);
        chk("a_busy_up", busy, 1);
        chk("a_adrs0", reg_dbg_adrs, 0);
        wait_done("a_done_seen");
        chk("a_first_low", first_low - sedge, 3);
        repeat (20) tick();
        chk("a_bytes", rx_bytes, N_BYTES);
        chk("a_frames", frame_cycles, N_BYTES * 40);
        chk("a_done_cnt", done_cnt, 1);
        chk("a_sb_left", exp_q.size(), 0);
        chk("a_adr5_hold", (adr5_cnt >= 2), 1);
        chk("a_idle_busy", busy, 0);
        chk("a_idle_tx", tx, 1);

        // start while busy is ignored
        reset_counters();
        push_dump();
        pulse_start(sedge);
        n = 0;
        while (rx_bytes < 50 && n < 5000) begin
            tick();
            n++;
        end
        chk("b_reach50", (rx_bytes >= 50), 1);
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        wait_done("b_done_seen");
        repeat (300) tick();
        chk("b_bytes", rx_bytes, N_BYTES);
        chk("b_done_cnt", done_cnt, 1);
        chk("b_sb_left", exp_q.size(), 0);
        chk("b_idle_busy", busy, 0);

        // reset during byte 100, data bit 3
        reset_counters();
        push_dump();
        pulse_start(sedge);
        n = 0;
        while (!(rx_bytes == 99 && mon_active && mon_cnt >= 17 && mon_cnt <= 19) && n < 8000) begin
            tick();
            n++;
        end
        chk("c_reach_bit3", (n < 8000), 1);
        reset = 1'b1;
        tick();
        chk("c_rst_tx", tx, 1);
        chk("c_rst_busy", busy, 0);
        chk("c_rst_adrs", reg_dbg_adrs, 0);
        reset = 1'b0;
        exp_q.delete();
        repeat (50) tick();
        chk("c_no_done", done_cnt, 0);
        chk("c_tx_idle", tx, 1);
        chk("c_bytes_abort", rx_bytes, 99);

        reset_counters();
        push_dump();
        pulse_start(sedge);
        wait_done("c_done_seen");
        repeat (20) tick();
        chk("c_first_low", first_low - sedge, 3);
        chk("c_bytes", rx_bytes, N_BYTES);
        chk("c_done_cnt", done_cnt, 1);
        chk("c_sb_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
